// File: rtl/font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : font_rom_arbiter
// Purpose  : Grants one requester per cycle access to the shared synchronous
//            font ROM (single-row reads or 16-row glyph bursts) and returns
//            each ROM byte tagged with requester ID, glyph row and last flag.
// Options  : FONT_ARB_FIXED_PRIO_EN - lowest requesting index always wins;
//            the round-robin pointer is not built. Undefined: round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module font_rom_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_burst,
  input  logic [11*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [10:0]          rom_addr,
  input  logic [7:0]           rom_data,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [3:0]           rsp_row,
  output logic                 rsp_last,
  output logic [7:0]           rsp_data,
  output logic                 busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  char_q, char_d;
  logic [3:0]  row_q, row_d;
  logic [2:0]  owner_q, owner_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_id_q, rsp_id_d;
  logic [3:0]  rsp_row_q, rsp_row_d;
  logic        rsp_last_q, rsp_last_d;
`ifndef FONT_ARB_FIXED_PRIO_EN
  logic [2:0]  ptr_q, ptr_d;
`endif

  logic        arb_found;
  logic [2:0]  arb_idx;
  logic [10:0] arb_addr;
  logic        arb_burst;
  int          cand;

  // Pick the first requester found, searching from the pointer (or from 0)
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 3'd0;
    arb_addr  = 11'd0;
    arb_burst = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FONT_ARB_FIXED_PRIO_EN
      cand = k;
`else
      // pointer + offset is below 2*NUM_REQ, so one subtraction wraps it
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = 3'(cand);
        arb_addr  = req_addr[cand*11 +: 11];
        arb_burst = req_burst[cand];
      end
    end
  end

  // Next-state, ROM address, grant and response-stage inputs
  always_comb begin
    state_d     = state_q;
    char_d      = char_q;
    row_d       = row_q;
    owner_d     = owner_q;
`ifndef FONT_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    rsp_valid_d = 1'b0;
    rsp_id_d    = 3'd0;
    rsp_row_d   = 4'd0;
    rsp_last_d  = 1'b0;
    gnt         = '0;
    rom_addr    = 11'd0;
    // Grant and ROM address are forced quiet while reset is held
    if (RST_N) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            gnt         = {{(NUM_REQ-1){1'b0}}, 1'b1} << arb_idx;
            rsp_valid_d = 1'b1;
            rsp_id_d    = arb_idx;
`ifndef FONT_ARB_FIXED_PRIO_EN
            ptr_d       = (arb_idx == 3'(NUM_REQ-1)) ? 3'd0 : arb_idx + 3'd1;
`endif
            if (arb_burst) begin
              // Beat 0 goes out in the grant cycle; BURST covers rows 1..15
              rom_addr   = {arb_addr[10:4], 4'd0};
              owner_d    = arb_idx;
              char_d     = arb_addr[10:4];
              row_d      = 4'd1;
              state_d    = ST_BURST;
              rsp_row_d  = 4'd0;
              rsp_last_d = 1'b0;
            end else begin
              rom_addr   = arb_addr;
              rsp_row_d  = arb_addr[3:0];
              rsp_last_d = 1'b1;
            end
          end
        end
        ST_BURST: begin
          rom_addr    = {char_q, row_q};
          rsp_valid_d = 1'b1;
          rsp_id_d    = owner_q;
          rsp_row_d   = row_q;
          rsp_last_d  = (row_q == 4'hF);
          if (row_q == 4'hF) begin
            row_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, burst context and response pipeline registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      char_q      <= 7'd0;
      row_q       <= 4'd0;
      owner_q     <= 3'd0;
`ifndef FONT_ARB_FIXED_PRIO_EN
      ptr_q       <= 3'd0;
`endif
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 3'd0;
      rsp_row_q   <= 4'd0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      char_q      <= char_d;
      row_q       <= row_d;
      owner_q     <= owner_d;
`ifndef FONT_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_row_q   <= rsp_row_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign busy      = (state_q == ST_BURST);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_row   = rsp_row_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rom_data;

endmodule
`default_nettype wire

// File: tb/tb_font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_font_rom_arbiter
// Purpose  : Directed scoreboard bench for font_rom_arbiter (NUM_REQ=4).
//            Stimulus pushes expected responses; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_font_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_burst;
  logic [43:0] req_addr;
  logic [3:0]  gnt;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [3:0]  rsp_row;
  logic        rsp_last;
  logic [7:0]  rsp_data;
  logic        busy;

  typedef struct packed {
    logic [2:0] id;
    logic [3:0] row;
    logic       last;
    logic [7:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done  = 1'b0;

  font_rom_arbiter #(.NUM_REQ(4)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .req       (req),
    .req_burst (req_burst),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_row   (rsp_row),
    .rsp_last  (rsp_last),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Font ROM content: arbitrary but address-dependent pattern
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    rom_fn = a[7:0] ^ {a[10:8], 5'h0B};
  endfunction

  // Synchronous ROM with one cycle of read latency
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_addr(input int i, input logic [10:0] a);
    req_addr[i*11 +: 11] = a;
  endtask

  // One cycle: check combinational outputs mid-cycle, optionally queue the
  // response due next cycle, then advance to just after the rising edge.
  // rv < 0 means rsp_valid is not checked directly this cycle.
  task automatic step(input logic [3:0] eg, input logic [10:0] ea, input logic eb,
                      input logic psh, input logic [2:0] id, input logic [3:0] row,
                      input logic lst, input int rv);
    rsp_t e;
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("rom_addr", 32'(rom_addr), 32'(ea));
    chk("busy", 32'(busy), 32'(eb));
    if (rv >= 0) chk("rsp_valid", 32'(rsp_valid), 32'(rv));
    if (psh) begin
      e.id   = id;
      e.row  = row;
      e.last = lst;
      e.data = rom_fn(ea);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    rsp_t e;
    while (!done) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got id %0d row %0d expected no response at %0t",
                   rsp_id, rsp_row, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_row", 32'(rsp_row), 32'(e.row));
          chk("rsp_last", 32'(rsp_last), 32'(e.last));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic stimulus();
    // ---------------- reset ----------------
    rst_n = 1'b0; req = '0; req_burst = '0; req_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_row", 32'(rsp_row), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef FONT_ARB_FIXED_PRIO_EN
    // ---------------- fixed priority ----------------
    req = 4'b1010;
    set_addr(1, 11'h155);
    set_addr(3, 11'h3A2);
    repeat (4) step(4'b0010, 11'h155, 1'b0, 1'b1, 3'd1, 4'h5, 1'b1, -1);
    req = '0;
    step(4'b0000, 11'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1);
`else
    // ---------------- round-robin singles ----------------
    req = 4'b1111;
    set_addr(0, 11'h103);
    set_addr(1, 11'h114);
    set_addr(2, 11'h125);
    set_addr(3, 11'h136);
    step(4'b0001, 11'h103, 1'b0, 1'b1, 3'd0, 4'h3, 1'b1, 0);
    step(4'b0010, 11'h114, 1'b0, 1'b1, 3'd1, 4'h4, 1'b1, 1);
    step(4'b0100, 11'h125, 1'b0, 1'b1, 3'd2, 4'h5, 1'b1, 1);
    step(4'b1000, 11'h136, 1'b0, 1'b1, 3'd3, 4'h6, 1'b1, 1);
    step(4'b0001, 11'h103, 1'b0, 1'b1, 3'd0, 4'h3, 1'b1, 1);
    // pointer now at 1
    // ---------------- idle ----------------
    req = '0;
    step(4'b0000, 11'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1);
    step(4'b0000, 11'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 0);
    step(4'b0000, 11'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 0);

    // ---------------- burst with contention ----------------
    req = 4'b0100; req_burst = 4'b0100;
    set_addr(2, {7'h41, 4'h7});
    step(4'b0100, 11'h410, 1'b0, 1'b1, 3'd2, 4'd0, 1'b0, 0);
    req = '0; req_burst = '0;
    for (int r = 1; r < 16; r++) begin
      if (r == 1) set_addr(2, 11'h7FF);
      if (r == 2) begin
        req = 4'b0001;
        set_addr(0, {7'h22, 4'h5});
      end
      step(4'b0000, {7'h41, 4'(r)}, 1'b1, 1'b1, 3'd2, 4'(r), (r == 15), (r == 1) ? -1 : 1);
    end
    step(4'b0001, 11'h225, 1'b0, 1'b1, 3'd0, 4'h5, 1'b1, 1);
    req = '0;
    step(4'b0000, 11'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1);
    // pointer now at 1

    // ---------------- reset mid-burst ----------------
    req = 4'b0010; req_burst = 4'b0010;
    set_addr(1, {7'h30, 4'h9});
    step(4'b0010, 11'h300, 1'b0, 1'b1, 3'd1, 4'd0, 1'b0, 0);
    req = '0; req_burst = '0;
    for (int r = 1; r < 8; r++)
      step(4'b0000, {7'h30, 4'(r)}, 1'b1, 1'b1, 3'd1, 4'(r), 1'b0, 1);
    rst_n = 1'b0;
    step(4'b0000, 11'h000, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1);
    step(4'b0000, 11'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 0);
    rst_n = 1'b1;
    req = 4'b0101;
    set_addr(0, 11'h0A1);
    set_addr(2, 11'h2B2);
    step(4'b0001, 11'h0A1, 1'b0, 1'b1, 3'd0, 4'h1, 1'b1, 0);
    step(4'b0100, 11'h2B2, 1'b0, 1'b1, 3'd2, 4'h2, 1'b1, 1);
    step(4'b0001, 11'h0A1, 1'b0, 1'b1, 3'd0, 4'h1, 1'b1, 1);
    req = '0;
    step(4'b0000, 11'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1);
`endif
    step(4'b0000, 11'h000, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 0);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    chk("pending_rsp", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
